// File: rtl/pc_fetch_ctrl.sv
// PC register and single-outstanding instruction-fetch sequencer with valid/ready delivery to decode.
// Optional MISALIGN_TRAP_EN: a misaligned PC load traps into HALT instead of clearing the low bits.
module pc_fetch_ctrl #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_next,
  input  logic             redirect,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [WIDTH-1:0] if_pc,
`ifdef MISALIGN_TRAP_EN
  output logic             fetch_misaligned,
`endif
  input  logic             id_ready
);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_WAIT  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DROP  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] pc_r;
  logic             if_valid_r;
  logic [31:0]      if_instr_r;
  logic [WIDTH-1:0] if_pc_r;
  logic             pc_load_s;
  logic             capture_s;
  logic             clear_s;

`ifdef MISALIGN_TRAP_EN
  logic             trap_s;
  logic             fetch_misaligned_r;
  assign fetch_misaligned = fetch_misaligned_r;
`else
  logic             unused_pc_next_lsb_s;
  assign unused_pc_next_lsb_s = ^pc_next[1:0];
`endif

  assign pc        = pc_r;
  assign pc_plus4  = pc_r + {{(WIDTH-3){1'b0}}, 3'b100};
  assign imem_addr = pc_r;
  assign imem_req  = (state_r == ST_FETCH) && !reset;
  assign if_valid  = if_valid_r;
  assign if_instr  = if_instr_r;
  assign if_pc     = if_pc_r;

  // Next-state and PC/instruction update decisions; redirect outranks normal sequencing.
  always_comb begin
    state_nxt_s = state_r;
    pc_load_s   = 1'b0;
    capture_s   = 1'b0;
    clear_s     = 1'b0;
    if (redirect && (state_r != ST_HALT)) begin
      pc_load_s = 1'b1;
      clear_s   = 1'b1;
      // A request still in flight must be drained before the next fetch.
      case (state_r)
        ST_FETCH: state_nxt_s = ST_DROP;
        ST_WAIT:  state_nxt_s = imem_rvalid ? ST_FETCH : ST_DROP;
        ST_HOLD:  state_nxt_s = ST_FETCH;
        ST_DROP:  state_nxt_s = imem_rvalid ? ST_FETCH : ST_DROP;
        default:  state_nxt_s = ST_FETCH;
      endcase
    end else begin
      case (state_r)
        ST_FETCH: state_nxt_s = ST_WAIT;
        ST_WAIT: begin
          if (imem_rvalid) begin
            capture_s   = 1'b1;
            pc_load_s   = 1'b1;
            state_nxt_s = ST_HOLD;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (id_ready) begin
            clear_s     = 1'b1;
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end
        ST_DROP:  state_nxt_s = imem_rvalid ? ST_FETCH : ST_DROP;
        ST_HALT:  state_nxt_s = ST_HALT;
        default:  state_nxt_s = ST_FETCH;
      endcase
    end
`ifdef MISALIGN_TRAP_EN
    trap_s = 1'b0;
    // A misaligned load freezes the PC at its previous value and parks in HALT.
    if (pc_load_s && (pc_next[1:0] != 2'b00)) begin
      trap_s      = 1'b1;
      pc_load_s   = 1'b0;
      capture_s   = 1'b0;
      clear_s     = 1'b1;
      state_nxt_s = ST_HALT;
    end else begin
      trap_s = 1'b0;
    end
`endif
  end

  // State, PC and decode-side registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_FETCH;
      pc_r       <= RESET_PC;
      if_valid_r <= 1'b0;
      if_instr_r <= 32'd0;
      if_pc_r    <= {WIDTH{1'b0}};
`ifdef MISALIGN_TRAP_EN
      fetch_misaligned_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      if (pc_load_s) begin
        pc_r <= {pc_next[WIDTH-1:2], 2'b00};
      end
      if (capture_s) begin
        if_instr_r <= imem_rdata;
        if_pc_r    <= pc_r;
        if_valid_r <= 1'b1;
      end else if (clear_s) begin
        if_valid_r <= 1'b0;
      end
`ifdef MISALIGN_TRAP_EN
      if (trap_s) begin
        fetch_misaligned_r <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: memory model with variable latency, bench-side PC mux,
// directed scenarios followed by randomized redirect/backpressure/reset traffic.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] tgt;
  logic [31:0] pc_next;
  logic [31:0] pc, pc_plus4, imem_addr, if_pc;
  logic        imem_req, imem_rvalid, if_valid, id_ready;
  logic [31:0] imem_rdata, if_instr;
`ifdef MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          mem_lat  = 1;
  int          acc_count = 0;
  logic [31:0] exp_q[$];
  logic [31:0] acc_log[$];
  int          req_cyc[$];
  logic [31:0] req_addr[$];

  assign pc_next = redirect ? tgt : pc_plus4;

  pc_fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .pc_next(pc_next), .redirect(redirect),
    .pc(pc), .pc_plus4(pc_plus4), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
`ifdef MISALIGN_TRAP_EN
    .fetch_misaligned(fetch_misaligned),
`endif
    .id_ready(id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0004) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic redir(input logic [31:0] t);
    redirect = 1'b1;
    tgt      = t;
    exp_q.delete();
    exp_q.push_back(t & 32'hFFFF_FFFC);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0000_0000);
    tick(1);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    tick(1);
    req_cyc.delete();
    req_addr.delete();
    acc_log.delete();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input logic [31:0] p);
    int n = 0;
    while (!(if_valid && if_pc == p) && n < 40) begin
      tick(1);
      n++;
    end
    check("wait_valid", 32'(if_valid), 32'd1);
    check("wait_valid_pc", if_pc, p);
  endtask

  task automatic wait_req(input logic [31:0] a);
    int n = 0;
    while (!imem_req && n < 40) begin
      tick(1);
      n++;
    end
    check("wait_req", 32'(imem_req), 32'd1);
    check("wait_req_addr", imem_addr, a);
  endtask

  // Instruction memory: one response per request, latency fixed by mem_lat or random 1..4.
  initial begin
    logic        pending;
    logic [31:0] paddr;
    int          cnt;
    pending     = 1'b0;
    paddr       = 32'd0;
    cnt         = 0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        pending = 1'b0;
      end else begin
        if (imem_rvalid) pending = 1'b0;
        if (imem_req) begin
          check("single_outstanding", 32'(pending), 32'd0);
          pending = 1'b1;
          paddr   = imem_addr;
          cnt     = (mem_lat > 0) ? mem_lat - 1 : int'($urandom_range(0, 3));
          req_cyc.push_back(cyc);
          req_addr.push_back(imem_addr);
        end else if (pending && cnt > 0) begin
          cnt--;
        end
      end
      #1;
      if (pending && cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(paddr);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted instruction and checks hold stability.
  initial begin
    logic        prev_hold;
    logic [31:0] prev_instr, prev_pc, e;
    prev_hold  = 1'b0;
    prev_instr = 32'd0;
    prev_pc    = 32'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        check("addr_eq_pc", imem_addr, pc);
        check("pc_plus4", pc_plus4, pc + 32'd4);
        if (prev_hold) begin
          check("hold_valid", 32'(if_valid), 32'd1);
          check("hold_instr", if_instr, prev_instr);
          check("hold_pc", if_pc, prev_pc);
        end
        if (if_valid && id_ready && !redirect) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got if_pc %h, expected no delivery", if_pc);
          end else begin
            e = exp_q.pop_front();
            check("sb_if_pc", if_pc, e);
            check("sb_if_instr", if_instr, mem_word(e));
            exp_q.push_back(e + 32'd4);
          end
          acc_log.push_back(if_pc);
          acc_count++;
        end
        prev_hold  = if_valid && !id_ready && !redirect;
        prev_instr = if_instr;
        prev_pc    = if_pc;
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    int          rel0;
    int          acc_base;
    logic [31:0] old_pc, t;
    reset    = 1'b1;
    redirect = 1'b0;
    tgt      = 32'd0;
    id_ready = 1'b1;
    mem_lat  = 1;
    tick(2);

    // Sequential fetch timing
    do_reset();
    rel0 = cyc;
    tick(10);
    if (req_cyc.size() >= 3) begin
      check("seq_cyc0", 32'(req_cyc[0] - rel0), 32'd1);
      check("seq_cyc1", 32'(req_cyc[1] - rel0), 32'd4);
      check("seq_cyc2", 32'(req_cyc[2] - rel0), 32'd7);
      check("seq_addr0", req_addr[0], 32'h0);
      check("seq_addr1", req_addr[1], 32'h4);
      check("seq_addr2", req_addr[2], 32'h8);
    end else begin
      check("seq_req_count", 32'(req_cyc.size()), 32'd3);
    end
    check("seq_acc_count", 32'(acc_log.size()), 32'd3);

    // Backpressure on the 0x4 instruction
    do_reset();
    wait_valid(32'h0);
    tick(1);
    id_ready = 1'b0;
    wait_valid(32'h4);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(if_valid), 32'd1);
      check("bp_instr", if_instr, 32'h0050_0093);
      check("bp_pc", if_pc, 32'h4);
      check("bp_req", 32'(imem_req), 32'd0);
      tick(1);
    end
    id_ready = 1'b1;
    mem_lat  = 3;
    tick(1);
    check("bp_release_valid", 32'(if_valid), 32'd0);
    check("bp_release_req", 32'(imem_req), 32'd1);
    check("bp_release_addr", imem_addr, 32'h8);

    // Redirect while the 0x8 response is pending
    tick(1);
    redir(32'h100);
    tick(1);
    redirect = 1'b0;
    mem_lat  = 1;
    check("drop_req", 32'(imem_req), 32'd0);
    check("drop_pc", pc, 32'h100);
    wait_req(32'h100);

    // Redirect coinciding with the response
    tick(1);
    redir(32'h200);
    tick(1);
    redirect = 1'b0;
    check("coinc_valid", 32'(if_valid), 32'd0);
    check("coinc_req", 32'(imem_req), 32'd1);
    check("coinc_addr", imem_addr, 32'h200);

    // Reset while holding an instruction
    id_ready = 1'b0;
    wait_valid(32'h200);
    do_reset();
    #1;
    check("post_rst_req", 32'(imem_req), 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);
    id_ready = 1'b1;

    // PC wrap
    redir(32'hFFFF_FFFC);
    tick(1);
    redirect = 1'b0;
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    tick(15);

    // Misaligned redirect target
`ifdef MISALIGN_TRAP_EN
    old_pc   = pc;
    redirect = 1'b1;
    tgt      = 32'h102;
    exp_q.delete();
    tick(1);
    check("mis_flag", 32'(fetch_misaligned), 32'd1);
    check("mis_pc", pc, old_pc);
    tgt = 32'h300;
    for (int i = 0; i < 4; i++) begin
      check("halt_req", 32'(imem_req), 32'd0);
      check("halt_valid", 32'(if_valid), 32'd0);
      check("halt_pc", pc, old_pc);
      tick(1);
    end
    redirect = 1'b0;
    do_reset();
    check("mis_cleared", 32'(fetch_misaligned), 32'd0);
`else
    old_pc = pc;
    redir(32'h102);
    tick(1);
    redirect = 1'b0;
    check("mis_pc_cleared", pc, 32'h100);
    wait_req(32'h100);
    check("mis_pc_moved", 32'(pc != old_pc || old_pc == 32'h100), 32'd1);
`endif

    // Randomized traffic
    mem_lat  = 0;
    acc_base = acc_count;
    for (int i = 0; i < 3000; i++) begin
      id_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 299) == 0) begin
        reset    = 1'b1;
        redirect = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0);
      end else begin
        reset = 1'b0;
        if ($urandom_range(0, 11) == 0) begin
          t = $urandom;
          if (t[4]) t = t | 32'hFFFF_FF00;
          redir(t & 32'hFFFF_FFFC);
        end else begin
          redirect = 1'b0;
        end
      end
      tick(1);
    end
    reset    = 1'b0;
    redirect = 1'b0;
    tick(5);
    check("random_progress", 32'((acc_count - acc_base) >= 50), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
